// File: rtl/cmd_auth_rx.sv
// 8N1 UART command receiver feeding a power-authorization FSM.
// 'G' powers up; 'S' powers down at once if the rider is off, else once the rider steps off.
module cmd_auth_rx #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter logic [7:0]  CMD_GO   = 8'h47,
  parameter logic [7:0]  CMD_STOP = 8'h53
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frame_err,
  output logic       pwr_up
);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE
  } rx_state_t;

  typedef enum logic [1:0] {
    AUTH_OFF, AUTH_PWR1, AUTH_PWR2
  } auth_state_t;

  // Counting down to zero inclusive, so a reload of N-1 spans exactly N cycles per bit.
  localparam logic [15:0] BIT_RELOAD  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(BAUD_DIV / 2);

  logic        rx_meta_q, rx_s_q;
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_rdy_q, rx_rdy_d;
  logic        frame_err_q, frame_err_d;
  auth_state_t auth_q, auth_d;
  logic        pwr_up_q;
  logic        byte_vld;
  logic        baud_tick;

  assign baud_tick = (baud_cnt_q == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_state_q  <= RX_IDLE;
      baud_cnt_q  <= 16'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      rx_data_q   <= 8'd0;
      rx_rdy_q    <= 1'b0;
      frame_err_q <= 1'b0;
      auth_q      <= AUTH_OFF;
      pwr_up_q    <= 1'b0;
    end else begin
      rx_meta_q   <= RX;
      rx_s_q      <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_rdy_q    <= rx_rdy_d;
      frame_err_q <= frame_err_d;
      auth_q      <= auth_d;
      pwr_up_q    <= (auth_d != AUTH_OFF);
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_rdy_d    = 1'b0;
    frame_err_d = 1'b0;
    byte_vld    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          baud_cnt_d = HALF_RELOAD;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (!baud_tick) begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end else if (!rx_s_q) begin
          baud_cnt_d = BIT_RELOAD;
          bit_cnt_d  = 3'd0;
          rx_state_d = RX_DATA;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (!baud_tick) begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end else begin
          shift_d    = {rx_s_q, shift_q[7:1]};
          baud_cnt_d = BIT_RELOAD;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (!baud_tick) begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end else if (rx_s_q) begin
          rx_data_d  = shift_q;
          rx_rdy_d   = 1'b1;
          byte_vld   = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          frame_err_d = 1'b1;
          rx_state_d  = RX_WAIT_IDLE;
        end
      end
      RX_WAIT_IDLE: begin
        if (rx_s_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Auth reacts to the byte as it is framed, so pwr_up moves on the same edge as rx_rdy.
  always_comb begin
    auth_d = auth_q;
    case (auth_q)
      AUTH_OFF: begin
        if (byte_vld && shift_q == CMD_GO) auth_d = AUTH_PWR1;
      end
      AUTH_PWR1: begin
        if (byte_vld && shift_q == CMD_STOP) auth_d = rider_off ? AUTH_OFF : AUTH_PWR2;
      end
      AUTH_PWR2: begin
        if (byte_vld && shift_q == CMD_GO) auth_d = AUTH_PWR1;
        else if (rider_off)                auth_d = AUTH_OFF;
      end
      default: auth_d = AUTH_OFF;
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_rdy    = rx_rdy_q;
  assign frame_err = frame_err_q;
  assign pwr_up    = pwr_up_q;

endmodule

// File: tb/tb_cmd_auth_rx.sv
// Directed bench for cmd_auth_rx: a serial driver, a monitor of rx_rdy/frame_err,
// and a queue of expected (byte, pwr_up) results checked as each frame lands.
module tb_cmd_auth_rx;

  localparam int B = 32;

  typedef struct packed {
    logic [7:0] data;
    logic       pwr;
  } exp_t;

  typedef struct packed {
    logic [7:0] data;
    logic       pwr;
    int         cyc;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b1;
  logic       rider_off = 1'b0;
  logic [7:0] rx_data;
  logic       rx_rdy, frame_err, pwr_up;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ferr_cnt = 0;
  int   obs_rd = 0;
  exp_t exp_q[$];
  obs_t obs_q[$];

  cmd_auth_rx #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst(rst), .RX(RX), .rider_off(rider_off),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .frame_err(frame_err), .pwr_up(pwr_up)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && rx_rdy) obs_q.push_back('{data: rx_data, pwr: pwr_up, cyc: cyc});
    if (!rst && frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    tick(B);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(B);
    end
    RX = stop_bit;
    tick(B);
    RX = 1'b1;
  endtask

  task automatic check_rx(input string tag);
    exp_t e;
    while (obs_rd < obs_q.size()) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_unexpected_rdy"}, 32'(obs_q[obs_rd].data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_data"}, 32'(obs_q[obs_rd].data), 32'(e.data));
        chk({tag, "_pwr"}, 32'(obs_q[obs_rd].pwr), 32'(e.pwr));
      end
      obs_rd++;
    end
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n0;
    int f0;

    tick(5);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_rdy", 32'(rx_rdy), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_pwr_up", 32'(pwr_up), 32'd0);
    rst = 1'b0;
    tick(3 * B);

    exp_q.push_back('{data: 8'h47, pwr: 1'b1});
    send_byte(8'h47, 1'b1);
    tick(2 * B);
    check_rx("go");

    exp_q.push_back('{data: 8'h53, pwr: 1'b1});
    send_byte(8'h53, 1'b1);
    tick(2 * B);
    check_rx("stop_rider_on");
    tick(10000);
    rider_off = 1'b1;
    chk("pwr2_hold", 32'(pwr_up), 32'd1);
    tick(1);
    chk("pwr2_rider_off", 32'(pwr_up), 32'd0);

    exp_q.push_back('{data: 8'h47, pwr: 1'b1});
    send_byte(8'h47, 1'b1);
    tick(2 * B);
    exp_q.push_back('{data: 8'h53, pwr: 1'b0});
    send_byte(8'h53, 1'b1);
    tick(2 * B);
    exp_q.push_back('{data: 8'h41, pwr: 1'b0});
    send_byte(8'h41, 1'b1);
    tick(2 * B);
    check_rx("stop_rider_off");
    chk("unknown_rx_data", 32'(rx_data), 32'h41);

    rider_off = 1'b0;
    n0 = obs_q.size();
    f0 = ferr_cnt;
    send_byte(8'h47, 1'b0);
    tick(2 * B);
    chk("ferr_count", 32'(ferr_cnt - f0), 32'd1);
    chk("ferr_no_rdy", 32'(obs_q.size() - n0), 32'd0);
    chk("ferr_rx_data", 32'(rx_data), 32'h41);
    chk("ferr_pwr", 32'(pwr_up), 32'd0);
    exp_q.push_back('{data: 8'h47, pwr: 1'b1});
    send_byte(8'h47, 1'b1);
    tick(2 * B);
    check_rx("after_ferr");

    n0 = obs_q.size();
    f0 = ferr_cnt;
    RX = 1'b0;
    tick(B / 4);
    RX = 1'b1;
    tick(3 * B);
    chk("glitch_no_rdy", 32'(obs_q.size() - n0), 32'd0);
    chk("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);

    exp_q.push_back('{data: 8'h47, pwr: 1'b1});
    exp_q.push_back('{data: 8'h53, pwr: 1'b1});
    send_byte(8'h47, 1'b1);
    send_byte(8'h53, 1'b1);
    tick(2 * B);
    chk("b2b_count", 32'(obs_q.size() - n0), 32'd2);
    if (obs_q.size() >= n0 + 2)
      chk("b2b_gap", 32'(obs_q[n0 + 1].cyc - obs_q[n0].cyc), 32'(10 * B));
    check_rx("b2b");

    n0 = obs_q.size();
    f0 = ferr_cnt;
    RX = 1'b0;
    tick(B);
    for (int i = 0; i < 4; i++) begin
      RX = (i < 3) ? 1'b1 : 1'b0;
      tick(B);
    end
    RX = 1'b0;
    tick(B / 2);
    rst = 1'b1;
    RX = 1'b1;
    tick(1);
    chk("midrst_rx_data", 32'(rx_data), 32'd0);
    chk("midrst_rx_rdy", 32'(rx_rdy), 32'd0);
    chk("midrst_frame_err", 32'(frame_err), 32'd0);
    chk("midrst_pwr_up", 32'(pwr_up), 32'd0);
    tick(3);
    rst = 1'b0;
    tick(12 * B);
    chk("midrst_no_rdy", 32'(obs_q.size() - n0), 32'd0);
    chk("midrst_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    exp_q.push_back('{data: 8'h47, pwr: 1'b1});
    send_byte(8'h47, 1'b1);
    tick(2 * B);
    check_rx("after_rst");

    chk("ferr_total", 32'(ferr_cnt), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
